// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch control. Owns the fetch PC, drives the
// synchronous instruction memory and chooses the next fetch address. The
// sources are redirect (EX branch, then ID jump), halt, stall and sequential
// fetch. Stall and redirect counters saturate and exist for debug.
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             br_taken_i,
  input  logic [15:0]      br_target_i,
  input  logic             jmp_i,
  input  logic [15:0]      jmp_addr_i,
  input  logic             hlt_i,
  output logic [15:0]      im_addr_o,
  output logic             im_rd_en_o,
  output logic [15:0]      pc_o,
  output logic             if_valid_o,
  output logic             flush_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] redir_cnt_o
);

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  // Per-cycle decision. The FSM picks one action and the datapath applies it.
  typedef enum logic [2:0] {
    ACT_NONE,   // in reset or halted: nothing moves
    ACT_REDIR,  // branch or jump: load target and squash the wrong-path fetch
    ACT_HALT,   // enter HALT and squash the current fetch
    ACT_STALL,  // freeze the fetch stage
    ACT_SEQ     // fetch the next sequential address
  } act_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  act_t             act;
  logic [15:0]      fetch_pc_q, fetch_pc_d;
  logic [15:0]      pc_q, pc_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;
  logic [15:0]      redir_target;

  // A branch resolved in EX is older than a jump decoded in ID, so it wins.
  assign redir_target = br_taken_i ? br_target_i : jmp_addr_i;

  // State register. HALT is left only through reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, regardless of block order.
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  // Next state, chosen action and combinational IM and flush controls.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d    = state_q;
    act        = ACT_NONE;
    im_rd_en_o = 1'b0;
    flush_o    = 1'b0;
    if (!rst && state_q == S_RUN) begin
      if (br_taken_i || jmp_i) begin
        // The redirect squashes a same-cycle halt, which is on the wrong path.
        act        = ACT_REDIR;
        im_rd_en_o = 1'b1;
        flush_o    = 1'b1;
      end else if (hlt_i) begin
        act     = ACT_HALT;
        flush_o = 1'b1;
        state_d = S_HALT;
      end else if (stall_i) begin
        act = ACT_STALL;
      end else begin
        act        = ACT_SEQ;
        im_rd_en_o = 1'b1;
      end
    end
  end

  // Datapath next values for the chosen action. The default is to hold.
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    redir_cnt_d = redir_cnt_q;
    case (act)
      ACT_REDIR: begin
        // pc_o holds. The bubble is marked by valid going low.
        fetch_pc_d = redir_target;
        valid_d    = 1'b0;
        if (redir_cnt_q != CNT_MAX) redir_cnt_d = redir_cnt_q + CNT_ONE;
      end
      ACT_HALT: begin
        valid_d = 1'b0;
      end
      ACT_STALL: begin
        // The IM holds its output while read enable is low, so holding
        // pc and valid keeps the visible instruction frozen as a unit.
        if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      ACT_SEQ: begin
        // The IM returns data one cycle after the address, so pc_o lags by one.
        pc_d       = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + 16'd1;
        valid_d    = 1'b1;
      end
      default: begin
        // ACT_NONE: everything holds.
      end
    endcase
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q  <= RESET_PC;
      pc_q        <= RESET_PC;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign im_addr_o   = fetch_pc_q;
  assign pc_o        = pc_q;
  assign if_valid_o  = valid_q;
  assign halted_o    = (state_q == S_HALT);
  assign stall_cnt_o = stall_cnt_q;
  assign redir_cnt_o = redir_cnt_q;

endmodule
